bcd_scan_display: RTL and testbench

Consumes the 16-bit packed-BCD count from the 4-digit BCD counter and drives a 4-digit multiplexed common-anode 7-segment display. A load strobe snapshots the count into a shadow register so digits never tear. A prescaler sets the dwell time per digit, and a one-cycle all-off guard starts each digit slot to suppress ghosting. Options: leading-zero blanking, per-digit decimal points, and an invalid-BCD error flag.

---
 rtl/bcd_scan_display.sv | 134 +++++++++++++
 tb/tb_bcd_scan_display.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Multiplexes a 4-digit packed-BCD value onto a common-anode 7-segment
//   display. A load strobe snapshots bcd into a shadow register so a digit
//   never shows half of an old value and half of a new one. Each digit owns
//   a slot of SCAN_DIV cycles. The first cycle of every slot is an all-off
//   guard cycle that suppresses ghosting between digits.
//
// Parameters
//   SCAN_DIV   clock cycles per digit slot (>= 2); slot cycle 0 is the guard
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous reset, active-low
//   bcd         packed BCD {thousands, hundreds, tens, ones}
//   load        capture strobe: shadow <= bcd on a clk edge while high
//   blank_lz    blank leading zero digits (digit 0 is never blanked)
//   dp_mask     dp_mask[k] lights the decimal point of digit k
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   dp          decimal point, active-high
//   an          digit enables, active-low, one-hot-low
//   frame_tick  one-cycle pulse at the start of digit 0's slot
//   err         sticky: last captured value held a nibble > 9
module bcd_scan_display #(
   parameter int SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] bcd,
   input  logic        load,
   input  logic        blank_lz,
   input  logic [3:0]  dp_mask,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick,
   output logic        err
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [15:0]   shadow;
   logic [1:0]    idx;
   logic [CW-1:0] cnt;

   logic [3:0]    nib;
   logic          blank3, blank2, blank1, blanked;
   logic [6:0]    seg_n;
   logic          dp_n;
   logic [3:0]    an_n;
   logic          ft_n;
   logic          bcd_bad;

   function automatic logic [6:0] font(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;   // non-BCD nibble renders as a dash
      endcase
      return s;
   endfunction

   // Blanking cascades down from the thousands digit: a digit is only a
   // leading zero if every digit above it is also a leading zero.
   always_comb begin
      blank3 = blank_lz && (shadow[15:12] == 4'd0);
      blank2 = blank3   && (shadow[11:8]  == 4'd0);
      blank1 = blank2   && (shadow[7:4]   == 4'd0);
      case (idx)
         2'd3:    blanked = blank3;
         2'd2:    blanked = blank2;
         2'd1:    blanked = blank1;
         default: blanked = 1'b0;
      endcase
   end

   always_comb begin
      nib   = 4'(shadow >> {idx, 2'b00});
      seg_n = '0;
      dp_n  = 1'b0;
      an_n  = '1;
      ft_n  = (idx == 2'd0) && (cnt == '0);
      if ((cnt != '0) && !blanked) begin
         seg_n = font(nib);
         dp_n  = dp_mask[idx];
         an_n  = ~(4'b0001 << idx);
      end
   end

   always_comb begin
      bcd_bad = (bcd[3:0]   > 4'd9) || (bcd[7:4]   > 4'd9) ||
                (bcd[11:8]  > 4'd9) || (bcd[15:12] > 4'd9);
   end

   // Scan counters, shadow capture and the registered display outputs.
   // The outputs reflect the scan position one cycle earlier.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow     <= '0;
         idx        <= '0;
         cnt        <= '0;
         seg        <= '0;
         dp         <= 1'b0;
         an         <= '1;
         frame_tick <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (load) begin
            shadow <= bcd;
            err    <= bcd_bad;
         end
         seg        <= seg_n;
         dp         <= dp_n;
         an         <= an_n;
         frame_tick <= ft_n;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
//   Self-checking bench for bcd_scan_display (SCAN_DIV = 4). A reference
//   model derives the expected display from the count of clock edges since
//   reset, using plain division and modulo for slot and digit position. A
//   table of hand-computed frames and a few hand-written sequences cover
//   blanking, dashes, mid-slot loads and asynchronous reset.
module tb_bcd_scan_display;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] bcd;
   logic        load;
   logic        blank_lz;
   logic [3:0]  dp_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;
   logic        err;

   int errors = 0;
   int checks = 0;

   bcd_scan_display #(.SCAN_DIV(SD)) dut (
      .clk(clk), .reset_n(reset_n), .bcd(bcd), .load(load),
      .blank_lz(blank_lz), .dp_mask(dp_mask), .seg(seg), .dp(dp),
      .an(an), .frame_tick(frame_tick), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [6:0] s;
      logic       d;
      logic [3:0] a;
      logic       f;
   } disp_t;

   logic [6:0] font_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic disp_t predict(input int unsigned n, input logic [15:0] sh,
                                     input logic blz, input logic [3:0] dm);
      disp_t r;
      int unsigned dig;
      int unsigned pos;
      logic [15:0] upper;
      logic [3:0]  nb;
      dig   = (n / SD) % 4;
      pos   = n % SD;
      upper = sh >> (4 * dig);
      nb    = upper[3:0];
      r.f   = (dig == 0) && (pos == 0);
      r.s   = '0;
      r.d   = 1'b0;
      r.a   = 4'hF;
      // a digit is a leading zero when it and everything above it is zero
      if (pos != 0 && !(blz && dig != 0 && upper == 16'd0)) begin
         r.s = (nb > 9) ? 7'h40 : font_tbl[nb];
         r.d = dm[dig];
         r.a = ~(4'b0001 << dig);
      end
      return r;
   endfunction

   function automatic logic any_bad(input logic [15:0] v);
      logic b;
      b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] t;
         t = v >> (4 * i);
         if (t[3:0] > 4'd9) b = 1'b1;
      end
      return b;
   endfunction

   int unsigned m_n;
   logic [15:0] m_sh;
   logic        m_err;
   disp_t       e;
   logic        mchk = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_n   <= 0;
         m_sh  <= '0;
         m_err <= 1'b0;
         e     <= '{s: 7'h00, d: 1'b0, a: 4'hF, f: 1'b0};
      end else begin
         e   <= predict(m_n, m_sh, blank_lz, dp_mask);
         m_n <= m_n + 1;
         if (load) begin
            m_sh  <= bcd;
            m_err <= any_bad(bcd);
         end
      end
   end

   always @(negedge clk) begin
      if (mchk)
         check("model", {18'd0, seg, dp, an, frame_tick, err},
                        {18'd0, e.s, e.d, e.a, e.f, m_err});
   end

   // ---------------- table of whole frames ----------------
   typedef struct {
      logic [15:0] v;
      logic [3:0]  dm;
      logic        blz;
      logic [27:0] segs;   // {d3, d2, d1, d0}
      logic [3:0]  blank;  // digits expected dark
      logic        e_err;
   } vec_t;

   vec_t tbl [7];

   task automatic wait_ft();
      int unsigned k;
      k = 0;
      @(negedge clk);
      while (frame_tick !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("ft_timeout", {31'd0, frame_tick}, 32'd1);
   endtask

   task automatic do_load(input logic [15:0] v);
      bcd  = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic check_frame(input vec_t r);
      logic [6:0] es;
      logic       ed;
      logic [3:0] ea;
      int         dig;
      int         pos;
      wait_ft();
      for (int k = 0; k < 4 * SD; k++) begin
         if (k > 0) @(negedge clk);
         dig = k / SD;
         pos = k % SD;
         es  = 7'h00;
         ed  = 1'b0;
         ea  = 4'hF;
         if (pos != 0 && !r.blank[dig]) begin
            es = 7'(r.segs >> (7 * dig));
            ed = r.dm[dig];
            ea = ~(4'b0001 << dig);
         end
         check("frame", {19'd0, seg, dp, an, frame_tick},
                        {19'd0, es, ed, ea, (k == 0)});
      end
      check("frame_err", {31'd0, err}, {31'd0, r.e_err});
   endtask

   initial begin
      int unsigned k;
      logic [15:0] rv;

      tbl[0] = '{16'h1234, 4'b0100, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 1'b0};
      tbl[1] = '{16'h0007, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 4'b1110, 1'b0};
      tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b1110, 1'b0};
      tbl[3] = '{16'h12A4, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h40, 7'h66}, 4'b0000, 1'b1};
      tbl[4] = '{16'h0099, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h6F, 7'h6F}, 4'b0000, 1'b0};
      tbl[5] = '{16'h00A0, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h40, 7'h3F}, 4'b1100, 1'b1};
      tbl[6] = '{16'h0500, 4'b1111, 1'b1, {7'h00, 7'h6D, 7'h3F, 7'h3F}, 4'b1000, 1'b0};

      reset_n  = 1'b0;
      load     = 1'b0;
      bcd      = 16'h0000;
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;

      // load during reset must be ignored
      repeat (2) @(negedge clk);
      bcd  = 16'h12A4;
      load = 1'b1;
      @(negedge clk);
      mchk = 1'b1;
      check("reset", {18'd0, seg, dp, an, frame_tick, err}, {18'd0, 7'h00, 1'b0, 4'hF, 1'b0, 1'b0});

      reset_n = 1'b1;
      load    = 1'b0;
      @(negedge clk);
      check("first_guard", {27'd0, an, frame_tick}, {27'd0, 4'hF, 1'b1});
      for (int i = 0; i < SD - 1; i++) begin
         @(negedge clk);
         check("first_digit0", {21'd0, seg, an}, {21'd0, 7'h3F, 4'hE});
      end
      check("err_after_reset", {31'd0, err}, 32'd0);

      wait_ft();
      k = 0;
      @(negedge clk);
      k++;
      while (frame_tick !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("ft_period", k, 4 * SD);

      foreach (tbl[i]) begin
         blank_lz = tbl[i].blz;
         dp_mask  = tbl[i].dm;
         do_load(tbl[i].v);
         check_frame(tbl[i]);
      end

      // load mid-slot of digit 2: slot position must not move
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;
      do_load(16'h1234);
      wait_ft();
      repeat (2 * SD + 1) @(negedge clk);
      bcd  = 16'h5555;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("midslot_old", {21'd0, seg, an}, {21'd0, 7'h5B, 4'hB});
      @(negedge clk);
      check("midslot_new", {21'd0, seg, an}, {21'd0, 7'h6D, 4'hB});
      k = 0;
      while (frame_tick !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("midslot_period", k, 2 * SD - 3);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rv = 16'($urandom);
         for (int j = 0; j < 4; j++)
            rv = (rv & ~(16'hF << (4 * j))) | (16'($urandom_range(0, 11)) << (4 * j));
         if ($urandom_range(0, 1) == 1)
            rv = rv >> (4 * $urandom_range(0, 3));
         bcd      = rv;
         load     = ($urandom_range(0, 3) == 0);
         blank_lz = ($urandom_range(0, 3) != 0);
         dp_mask  = 4'($urandom);
         @(negedge clk);
      end
      load = 1'b0;

      // asynchronous reset in the middle of digit 2's slot
      blank_lz = 1'b0;
      do_load(16'h12A4);
      wait_ft();
      check("err_set", {31'd0, err}, 32'd1);
      repeat (2 * SD + 1) @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("async_reset", {18'd0, seg, dp, an, frame_tick, err}, {18'd0, 7'h00, 1'b0, 4'hF, 1'b0, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_reset_guard", {27'd0, an, frame_tick}, {27'd0, 4'hF, 1'b1});
      @(negedge clk);
      check("post_reset_d0", {21'd0, seg, an}, {21'd0, 7'h3F, 4'hE});
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
